// File: rtl/ttl245_bus_arbiter_if.sv
// Handshake and transceiver-control bundle between the requesters and ttl245_bus_arbiter.
// The arbiter attaches through the slave modport, the requester side through master.
interface ttl245_bus_arbiter_if #(
    parameter int NREQ = 2
);
    localparam int SELW = $clog2(NREQ);

    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] dir_i;
    logic [NREQ-1:0] grant_o;
    logic            xcvr_dir_o;
    logic            xcvr_oen_o;
    logic [SELW-1:0] mux_sel_o;
    logic            busy_o;
    logic            timeout_o;

    modport master (
        output req_i, dir_i,
        input  grant_o, xcvr_dir_o, xcvr_oen_o, mux_sel_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, dir_i,
        output grant_o, xcvr_dir_o, xcvr_oen_o, mux_sel_o, busy_o, timeout_o
    );
endinterface

// File: rtl/ttl245_bus_arbiter.sv
// Round-robin owner of a shared 74245 bus segment with setup and turnaround dead-time.
// Define BUSARB_TIMEOUT_EN to force a release after TIMEOUT active cycles.
module ttl245_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int SETUP_CYC = 2,
    parameter int TURN_CYC  = 1,
    parameter int TIMEOUT   = 64
) (
    input logic                 clk,
    input logic                 rst,
    ttl245_bus_arbiter_if.slave bus
);
    localparam int SELW = $clog2(NREQ);
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] TURN_LOAD  = 8'(TURN_CYC - 1);

    if (NREQ < 2 || NREQ > 4) begin : gBadNreq
        $error("ttl245_bus_arbiter: NREQ must be 2..4");
    end
    if (SETUP_CYC < 1 || SETUP_CYC > 255 || TURN_CYC < 1 || TURN_CYC > 255 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : gBadCycles
        $error("ttl245_bus_arbiter: SETUP_CYC, TURN_CYC, TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RELEASE} state_e;

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [SELW-1:0] owner_q;
    logic [SELW-1:0] ptr_q;
    logic [NREQ-1:0] grant_q;
    logic            dir_q;
    logic            oen_q;
    logic            busy_q;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] rot;
    logic [SELW-1:0] winner;
    logic [SELW-1:0] ownerNext;
    logic            anyEligible;
    logic            ownerReq;
    logic            forceRelease;
    int              offset;

    assign ownerReq  = bus.req_i[owner_q];
    assign ownerNext = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + SELW'(1);

`ifdef BUSARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

    logic [7:0]      activeCnt_q;
    logic [NREQ-1:0] blocked_q;
    logic            timeout_q;

    assign eligible      = bus.req_i & ~blocked_q;
    assign forceRelease  = (state_q == ACTIVE) && ownerReq && (activeCnt_q == TIMEOUT_VAL);
    assign bus.timeout_o = timeout_q;

    // A timed-out owner stays ineligible until it lowers its request once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            activeCnt_q <= 8'd1;
            blocked_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= forceRelease;
            blocked_q <= (blocked_q & bus.req_i) | (forceRelease ? (NREQ'(1) << owner_q) : '0);
            if (state_q != ACTIVE) begin
                activeCnt_q <= 8'd1;
            end else if (!forceRelease) begin
                activeCnt_q <= activeCnt_q + 8'd1;
            end
        end
    end
`else
    assign eligible      = bus.req_i;
    assign forceRelease  = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Rotate so bit 0 is the pointer position; the lowest set bit is the round-robin winner.
    assign rot = NREQ'({eligible, eligible} >> ptr_q);

    always_comb begin
        offset      = 0;
        anyEligible = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset      = i;
                anyEligible = 1'b1;
            end
        end
        winner = SELW'((int'(ptr_q) + offset) % NREQ);
    end

    // OEn is only pulled low in ACTIVE, so SETUP and RELEASE are the dead-time windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            dir_q   <= 1'b0;
            oen_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyEligible) begin
                        owner_q <= winner;
                        dir_q   <= bus.dir_i[winner];
                        cnt_q   <= SETUP_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (!ownerReq) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == 8'd0) begin
                        grant_q <= NREQ'(1) << owner_q;
                        oen_q   <= 1'b0;
                        state_q <= ACTIVE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACTIVE: begin
                    if (!ownerReq || forceRelease) begin
                        grant_q <= '0;
                        oen_q   <= 1'b1;
                        ptr_q   <= ownerNext;
                        cnt_q   <= TURN_LOAD;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.xcvr_dir_o = dir_q;
    assign bus.xcvr_oen_o = oen_q;
    assign bus.mux_sel_o  = owner_q;
    assign bus.busy_o     = busy_q;
endmodule
